// File: rtl/life_board_engine.sv
// ---------------------------------------------------------------------------
// life_board_engine
//
// Holds a ROW x COL Game of Life board. The board is loaded or unloaded over
// a LANES-bit stream and, on a run request, advanced by a programmable number
// of generations at one generation per clock. Cell k = r*COL + c, with row 0
// and column 0 being the top-left cell.
//
// Parameters
//   ROW, COL : board dimensions (each >= 3)
//   LANES    : bits per stream beat (ROW*COL must be a multiple of LANES)
//   WRAP     : 0 = cells outside the board are dead, 1 = toroidal board
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   run            start request (rising edge only)
//   write_read_not stream direction, 1 = load, 0 = unload
//   strobe         one beat transfer request
//   gen_count      number of generations, sampled on the run rising edge
//   serial_in      load beat data
//   serial_out     unload beat data (registered)
//   out_valid      serial_out holds a new beat
//   busy           generation run in progress
//   done           one-cycle pulse when a run completes
//   board_empty    all board bits are 0 (combinational)
// ---------------------------------------------------------------------------
module life_board_engine #(
    parameter int ROW   = 4,
    parameter int COL   = 4,
    parameter int LANES = 1,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             write_read_not,
    input  logic             strobe,
    input  logic [15:0]      gen_count,
    input  logic [LANES-1:0] serial_in,
    output logic [LANES-1:0] serial_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             board_empty
);

    localparam int N = ROW * COL;

    typedef enum logic {IDLE, STEP} state_t;

    state_t         state_reg;
    logic [N-1:0]   board_reg;
    logic [N-1:0]   board_next_gen;
    logic [N-1:0]   board_shifted;
    logic [N-1:0]   board_loaded;
    logic [15:0]    counter_reg;
    logic           run_q_reg;
    logic           start;

    assign start       = run & ~run_q_reg;
    assign board_empty = ~|board_reg;

    // Shift-right-by-one-beat views used by load and unload. Built with
    // shifts rather than part-selects so LANES == N stays legal.
    assign board_shifted = board_reg >> LANES;
    assign board_loaded  = board_shifted | (N'(serial_in) << (N - LANES));

    // Next generation: one combinational rule evaluator per cell.
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        localparam int R = gi / COL;
        localparam int C = gi % COL;

        logic [8:0] nb;
        logic [3:0] cnt;

        // Neighbour window is scanned as a 3x3 grid; slot 4 is the cell itself.
        for (genvar gj = 0; gj < 9; gj++) begin : g_nb
            localparam int RR = R + (gj / 3) - 1;
            localparam int CC = C + (gj % 3) - 1;
            localparam int RW = (RR + ROW) % ROW;
            localparam int CW = (CC + COL) % COL;
            localparam bit INSIDE = (RR >= 0) && (RR < ROW) && (CC >= 0) && (CC < COL);
            if (gj == 4) begin : g_self
                assign nb[gj] = 1'b0;
            end else if (INSIDE || (WRAP != 0)) begin : g_live
                assign nb[gj] = board_reg[RW*COL + CW];
            end else begin : g_dead
                assign nb[gj] = 1'b0;
            end
        end

        // At most 8 neighbours, so a 4-bit sum can never overflow.
        always_comb begin
            cnt = 4'd0;
            for (int j = 0; j < 9; j++) begin
                cnt = cnt + {3'b000, nb[j]};
            end
        end

        assign board_next_gen[gi] = (cnt == 4'd3) | (board_reg[gi] & (cnt == 4'd2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            board_reg   <= '0;
            counter_reg <= '0;
            run_q_reg   <= 1'b0;
            serial_out  <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            run_q_reg <= run;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A start edge wins over a strobe in the same cycle.
                    if (start) begin
                        if (gen_count == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            counter_reg <= gen_count;
                            busy        <= 1'b1;
                            state_reg   <= STEP;
                        end
                    end else if (strobe) begin
                        if (write_read_not) begin
                            board_reg <= board_loaded;
                        end else begin
                            // Unload is destructive: zeros fill from the top.
                            serial_out <= board_reg[LANES-1:0];
                            out_valid  <= 1'b1;
                            board_reg  <= board_shifted;
                        end
                    end
                end
                STEP: begin
                    board_reg   <= board_next_gen;
                    counter_reg <= counter_reg - 16'd1;
                    if (counter_reg == 16'd1) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
